// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 800x600 timing, counter widths and
// derived totals, used by the timing generator and by the renderer.
package vga_pkg;

    // Default 800x600 @ 72 Hz timing with a 50 MHz pixel clock
    localparam int DEF_H_VISIBLE = 800;
    localparam int DEF_H_FP      = 56;
    localparam int DEF_H_SYNC    = 120;
    localparam int DEF_H_BP      = 64;
    localparam int DEF_V_VISIBLE = 600;
    localparam int DEF_V_FP      = 37;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BP      = 23;
    localparam int DEF_SYNC_POL  = 1;

    // Coordinate and colour widths, and the largest periods they can count
    localparam int H_W         = 11;
    localparam int V_W         = 10;
    localparam int COLOR_W     = 4;
    localparam int H_MAX_TOTAL = 2048;
    localparam int V_MAX_TOTAL = 1024;

    // Length of one full period (line or frame) from its four segments
    function automatic int period_total(input int visible, input int fp,
                                        input int sync, input int bp);
        return visible + fp + sync + bp;
    endfunction

    localparam int H_TOTAL = period_total(DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
    localparam int V_TOTAL = period_total(DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_timing.sv
// VGA timing generator: free-running pixel/line counters, combinational
// visible-area and frame-start decode, and a single registered output stage
// for colour and sync pins so every pin lags the coordinates by one clock.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int SYNC_POL  = DEF_SYNC_POL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COLOR_W-1:0] i_red,
    input  logic [COLOR_W-1:0] i_green,
    input  logic [COLOR_W-1:0] i_blue,
    output logic [H_W-1:0]     h_coord,
    output logic [V_W-1:0]     v_coord,
    output logic               disp_enbl,
    output logic               frame_start,
    output logic [COLOR_W-1:0] vga_r,
    output logic [COLOR_W-1:0] vga_g,
    output logic [COLOR_W-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs
);

    localparam int H_TOT = period_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int V_TOT = period_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    // Refuse timing that the coordinate counters cannot represent
    generate
        if (H_TOT > H_MAX_TOTAL) begin : g_h_total_too_big
            $error("vga_timing: horizontal total exceeds counter range");
        end
        if (V_TOT > V_MAX_TOTAL) begin : g_v_total_too_big
            $error("vga_timing: vertical total exceeds counter range");
        end
    endgenerate

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOT - 1);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOT - 1);
    localparam logic [H_W-1:0] H_VIS_END  = H_W'(H_VISIBLE);
    localparam logic [V_W-1:0] V_VIS_END  = V_W'(V_VISIBLE);
    localparam logic [H_W-1:0] HS_FIRST   = H_W'(H_VISIBLE + H_FP);
    localparam logic [H_W-1:0] HS_LAST    = H_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] VS_FIRST   = V_W'(V_VISIBLE + V_FP);
    localparam logic [V_W-1:0] VS_LAST    = V_W'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic           SYNC_LEVEL = (SYNC_POL != 0);

    logic [H_W-1:0] h_count_reg;
    logic [H_W-1:0] h_count_next;
    logic [V_W-1:0] v_count_reg;
    logic [V_W-1:0] v_count_next;
    logic           hsync_raw;
    logic           vsync_raw;

    // Next counter values: pixel counter every clock, line counter on line end
    always_comb begin
        h_count_next = h_count_reg + 1'b1;
        v_count_next = v_count_reg;
        if (h_count_reg == H_LAST) begin
            h_count_next = '0;
            if (v_count_reg == V_LAST) begin
                v_count_next = '0;
            end else begin
                v_count_next = v_count_reg + 1'b1;
            end
        end
    end

    // Counter registers; reset restarts the frame at the top-left pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else begin
            h_count_reg <= h_count_next;
            v_count_reg <= v_count_next;
        end
    end

    // Decode of the current coordinates: visible area, frame start, raw syncs
    always_comb begin
        disp_enbl   = (h_count_reg < H_VIS_END) && (v_count_reg < V_VIS_END);
        frame_start = (h_count_reg == '0) && (v_count_reg == '0);
        hsync_raw   = (h_count_reg >= HS_FIRST) && (h_count_reg <= HS_LAST);
        vsync_raw   = (v_count_reg >= VS_FIRST) && (v_count_reg <= VS_LAST);
    end

    assign h_coord = h_count_reg;
    assign v_coord = v_count_reg;

    // Output stage: colour blanked outside the visible area, syncs at chosen polarity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~SYNC_LEVEL;
            vga_vs <= ~SYNC_LEVEL;
        end else begin
            vga_r  <= disp_enbl ? i_red   : '0;
            vga_g  <= disp_enbl ? i_green : '0;
            vga_b  <= disp_enbl ? i_blue  : '0;
            vga_hs <= hsync_raw ? SYNC_LEVEL : ~SYNC_LEVEL;
            vga_vs <= vsync_raw ? SYNC_LEVEL : ~SYNC_LEVEL;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing with a shrunken timing set so several whole frames fit
// in a short run. A reference model derives the coordinates from the number of
// clocks since reset release; expected pin values are queued and checked by a
// separate monitor one clock later.
module tb_vga_timing;

    localparam int TH_VIS  = 16;
    localparam int TH_FP   = 3;
    localparam int TH_SYNC = 5;
    localparam int TH_BP   = 4;
    localparam int TV_VIS  = 8;
    localparam int TV_FP   = 2;
    localparam int TV_SYNC = 3;
    localparam int TV_BP   = 2;
    localparam int HT      = TH_VIS + TH_FP + TH_SYNC + TH_BP;   // 28
    localparam int VT      = TV_VIS + TV_FP + TV_SYNC + TV_BP;   // 15
    localparam int FRAME   = HT * VT;                            // 420

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } pins_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  i_red = '0;
    logic [3:0]  i_green = '0;
    logic [3:0]  i_blue = '0;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic        disp_enbl;
    logic        frame_start;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;

    int    checks = 0;
    int    errors = 0;
    int    model_n = 0;
    int    cyc = 0;
    int    last_fs = -1;
    int    hs_run = 0;
    int    vs_run = 0;
    pins_t exp_q[$];

    vga_timing #(
        .H_VISIBLE(TH_VIS), .H_FP(TH_FP), .H_SYNC(TH_SYNC), .H_BP(TH_BP),
        .V_VISIBLE(TV_VIS), .V_FP(TV_FP), .V_SYNC(TV_SYNC), .V_BP(TV_BP),
        .SYNC_POL(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
        .h_coord(h_coord), .v_coord(v_coord),
        .disp_enbl(disp_enbl), .frame_start(frame_start),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // One clock of stimulus at a falling edge: check coordinates and decode,
    // drive new colours, queue the pins expected after the next rising edge.
    task automatic step(input bit force_red);
        int    h;
        int    v;
        bit    vis;
        pins_t e;
        h   = model_n % HT;
        v   = (model_n / HT) % VT;
        vis = (h < TH_VIS) && (v < TV_VIS);
        check("h_coord", int'(h_coord), h);
        check("v_coord", int'(v_coord), v);
        check("disp_enbl", int'(disp_enbl), int'(vis));
        check("frame_start", int'(frame_start), int'(h == 0 && v == 0));
        if (frame_start) begin
            if (last_fs >= 0) check("frame_gap", cyc - last_fs, FRAME);
            last_fs = cyc;
        end
        i_red   = force_red ? 4'hF : 4'($urandom_range(0, 15));
        i_green = 4'($urandom_range(0, 15));
        i_blue  = 4'($urandom_range(0, 15));
        e.r  = vis ? i_red   : 4'h0;
        e.g  = vis ? i_green : 4'h0;
        e.b  = vis ? i_blue  : 4'h0;
        e.hs = (h >= TH_VIS + TH_FP) && (h < TH_VIS + TH_FP + TH_SYNC);
        e.vs = (v >= TV_VIS + TV_FP) && (v < TV_VIS + TV_FP + TV_SYNC);
        exp_q.push_back(e);
        @(negedge clk);
        model_n++;
        cyc++;
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_h"}, int'(h_coord), 0);
        check({tag, "_v"}, int'(v_coord), 0);
        check({tag, "_rgb"}, int'({vga_r, vga_g, vga_b}), 0);
        check({tag, "_hs"}, int'(vga_hs), 0);
        check({tag, "_vs"}, int'(vga_vs), 0);
    endtask

    // Monitor: compare the registered pins with the queued expectation and
    // measure sync pulse widths.
    always @(posedge clk) begin
        pins_t e;
        #1;
        if (!rst_n) begin
            hs_run = 0;
            vs_run = 0;
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("vga_r", int'(vga_r), int'(e.r));
                check("vga_g", int'(vga_g), int'(e.g));
                check("vga_b", int'(vga_b), int'(e.b));
                check("vga_hs", int'(vga_hs), int'(e.hs));
                check("vga_vs", int'(vga_vs), int'(e.vs));
            end
            if (vga_hs) hs_run++;
            else begin
                if (hs_run > 0) check("hs_width", hs_run, TH_SYNC);
                hs_run = 0;
            end
            if (vga_vs) vs_run++;
            else begin
                if (vs_run > 0) check("vs_width", vs_run, TV_SYNC * HT);
                vs_run = 0;
            end
        end
    end

    initial begin
        // Reset asserted from time zero, before any clock edge
        #2;
        check_reset_pins("rst_init");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_n = 0;
        check("rel_hs", int'(vga_hs), 0);
        check("rel_vs", int'(vga_vs), 0);

        // Two frames of random colour, then one with red held at full scale
        for (int i = 0; i < 2 * FRAME; i++) step(1'b0);
        for (int i = 0; i < FRAME; i++) step(1'b1);

        // Run to a point inside both sync pulses, then reset without a clock edge
        for (int i = 0; i < 2 * FRAME; i++) begin
            if ((model_n % HT) == TH_VIS + TH_FP + 1 &&
                ((model_n / HT) % VT) == TV_VIS + TV_FP + 1) break;
            step(1'b0);
        end
        check("pre_rst_hs", int'(vga_hs), 1);
        check("pre_rst_vs", int'(vga_vs), 1);
        rst_n = 1'b0;
        #1;
        check_reset_pins("rst_mid");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_reset_pins("rst_hold");
        rst_n = 1'b1;
        model_n = 0;
        last_fs = -1;
        for (int i = 0; i < FRAME + HT; i++) step(1'b0);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
